mips_exec_unit: RTL and testbench

Single-cycle-datapath execute slice for the MIPS core. It combines three functions:
- ALU-control decode: ALUOp plus funct to a 4-bit ALU control code.
- 32-bit ALU: AND/OR/ADD/SUB/SLT/NOR with a zero flag.
- Sequential-PC adder: PC+4.

Results are captured in an output register so the stage presents stable values to memory/branch logic one cycle after the operands arrive.

---
 rtl/mips_exec_pkg.sv | 28 ++
 rtl/mips_exec_unit_if.sv | 30 +++
 rtl/alu_ctl_decode.sv | 35 +++
 rtl/mips_exec_unit.sv | 79 +++++++
 tb/tb_mips_exec_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_exec_pkg.sv
// Shared constants for the MIPS execute slice: ALUOp encodings from main
// control, 4-bit ALU control codes and the R-type funct values we decode.
package mips_exec_pkg;

  // ALUOp from main control
  localparam logic [1:0] ALUOP_MEM   = 2'b00;  // lw/sw address add
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;  // branch compare via subtract
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // operation chosen by funct
  localparam logic [1:0] ALUOP_IMM   = 2'b11;  // addi

  // ALU control codes
  localparam logic [3:0] CTL_AND     = 4'b0000;
  localparam logic [3:0] CTL_OR      = 4'b0001;
  localparam logic [3:0] CTL_ADD     = 4'b0010;
  localparam logic [3:0] CTL_SUB     = 4'b0110;
  localparam logic [3:0] CTL_SLT     = 4'b0111;
  localparam logic [3:0] CTL_NOR     = 4'b1100;
  localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/mips_exec_unit_if.sv
// Bus between the decode/operand stage and the execute slice.
//   master: drives valid_in, alu_op, funct, op_a, op_b, pc_in; observes results.
//   slave : the execute slice; drives alu_ctl (combinational) and the
//           registered alu_out, zero, pc_plus4, illegal, valid_out.
interface mips_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_in;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] pc_in;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic [WIDTH-1:0] pc_plus4;
  logic             illegal;
  logic             valid_out;

  modport master (
    output valid_in, alu_op, funct, op_a, op_b, pc_in,
    input  alu_ctl, alu_out, zero, pc_plus4, illegal, valid_out
  );

  modport slave (
    input  valid_in, alu_op, funct, op_a, op_b, pc_in,
    output alu_ctl, alu_out, zero, pc_plus4, illegal, valid_out
  );
endinterface

// File: rtl/alu_ctl_decode.sv
// ALU control decode: maps ALUOp and funct to the 4-bit ALU control code.
// Purely combinational.
//   alu_op  : ALUOp from main control
//   funct   : instruction funct field
//   alu_ctl : decoded control code (CTL_ILLEGAL for unsupported funct)
module alu_ctl_decode
  import mips_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = CTL_ILLEGAL;
    unique case (alu_op)
      ALUOP_MEM:   alu_ctl = CTL_ADD;
      ALUOP_BEQ:   alu_ctl = CTL_SUB;
      ALUOP_IMM:   alu_ctl = CTL_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctl = CTL_ADD;
          FUNCT_SUB: alu_ctl = CTL_SUB;
          FUNCT_AND: alu_ctl = CTL_AND;
          FUNCT_OR:  alu_ctl = CTL_OR;
          FUNCT_SLT: alu_ctl = CTL_SLT;
          FUNCT_NOR: alu_ctl = CTL_NOR;
          default:   alu_ctl = CTL_ILLEGAL;
        endcase
      end
      default:     alu_ctl = CTL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// Execute slice of the single-cycle MIPS datapath: ALU control decode, 32-bit
// ALU with zero flag and the sequential PC adder, with results registered so
// the downstream memory/branch logic sees stable values one cycle later.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all registered outputs
//   bus   : slave side of mips_exec_unit_if (operands in, results out)
module mips_exec_unit
  import mips_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PC_STEP = 4
) (
  input logic             clock,
  input logic             reset,
  mips_exec_unit_if.slave bus
);

  logic [3:0]       ctl;
  logic [WIDTH-1:0] result;
  logic             bad_ctl;
  logic [WIDTH-1:0] pc_next;

  logic [WIDTH-1:0] alu_out_q;
  logic             zero_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             illegal_q;
  logic             valid_q;

  alu_ctl_decode u_decode (
    .alu_op  (bus.alu_op),
    .funct   (bus.funct),
    .alu_ctl (ctl)
  );

  assign bus.alu_ctl = ctl;

  // Add/sub wrap silently; no overflow detection in this core.
  always_comb begin
    result  = '0;
    bad_ctl = 1'b0;
    case (ctl)
      CTL_AND: result = bus.op_a & bus.op_b;
      CTL_OR:  result = bus.op_a | bus.op_b;
      CTL_ADD: result = bus.op_a + bus.op_b;
      CTL_SUB: result = bus.op_a - bus.op_b;
      CTL_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      CTL_NOR: result = ~(bus.op_a | bus.op_b);
      default: bad_ctl = 1'b1;
    endcase
  end

  assign pc_next = bus.pc_in + WIDTH'(PC_STEP);

  // zero resets high to stay consistent with the cleared result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_out_q  <= '0;
      zero_q     <= 1'b1;
      pc_plus4_q <= '0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        alu_out_q  <= result;
        zero_q     <= (result == '0);
        pc_plus4_q <= pc_next;
        illegal_q  <= bad_ctl;
      end
    end
  end

  assign bus.alu_out   = alu_out_q;
  assign bus.zero      = zero_q;
  assign bus.pc_plus4  = pc_plus4_q;
  assign bus.illegal   = illegal_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the execute slice.
module tb_mips_exec_unit;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;
  bit   checking;

  mips_exec_unit_if #(.WIDTH(32)) bus ();

  mips_exec_unit #(.WIDTH(32), .PC_STEP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  function automatic bit is_known_funct(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
  endfunction

  function automatic logic [3:0] model_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd1) return 4'h6;
    if (op != 2'd2) return 4'h2;
    case (f)
      6'h20:   return 4'h2;
      6'h22:   return 4'h6;
      6'h24:   return 4'h0;
      6'h25:   return 4'h1;
      6'h2a:   return 4'h7;
      6'h27:   return 4'hc;
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (op == 2'd1) return a - b;
    if (op != 2'd2) return a + b;
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return (sa < sb) ? 32'd1 : 32'd0;
      6'h27:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] m_out;
  logic        m_zero;
  logic [31:0] m_pc;
  logic        m_ill;
  logic        m_valid;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_out   = 32'd0;
      m_zero  = 1'b1;
      m_pc    = 32'd0;
      m_ill   = 1'b0;
      m_valid = 1'b0;
    end else begin
      m_valid = bus.valid_in;
      if (bus.valid_in) begin
        m_out  = model_res(bus.alu_op, bus.funct, bus.op_a, bus.op_b);
        m_zero = (m_out == 32'd0);
        m_pc   = bus.pc_in + 32'd4;
        m_ill  = (bus.alu_op == 2'd2) && !is_known_funct(bus.funct);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (checking && !reset) begin
      chk("cmp_alu_ctl", 32'(bus.alu_ctl), 32'(model_ctl(bus.alu_op, bus.funct)));
      chk("cmp_alu_out", bus.alu_out, m_out);
      chk("cmp_zero", 32'(bus.zero), 32'(m_zero));
      chk("cmp_pc_plus4", bus.pc_plus4, m_pc);
      chk("cmp_illegal", 32'(bus.illegal), 32'(m_ill));
      chk("cmp_valid_out", 32'(bus.valid_out), 32'(m_valid));
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    bus.valid_in = v;
    bus.alu_op   = op;
    bus.funct    = f;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.pc_in    = pc;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  logic [5:0] legal_f [6];

  initial begin
    compared   = 0;
    mismatched = 0;
    checking   = 1'b0;
    legal_f    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    #3;
    chk("reset_alu_out", bus.alu_out, 32'd0);
    chk("reset_zero", 32'(bus.zero), 32'd1);
    chk("reset_pc_plus4", bus.pc_plus4, 32'd0);
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_illegal", 32'(bus.illegal), 32'd0);
    #9 reset = 1'b0;
    checking = 1'b1;
    #4;  // now at posedge(15)+1

    // R-type ADD
    drive(1'b1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h8);
    #1 chk("add_ctl", 32'(bus.alu_ctl), 32'h2);
    next_edge();
    chk("add_out", bus.alu_out, 32'd12);
    chk("add_zero", 32'(bus.zero), 32'd0);
    chk("add_pc", bus.pc_plus4, 32'hC);
    chk("add_valid", 32'(bus.valid_out), 32'd1);

    // beq equal / unequal
    drive(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1234, 32'h10);
    #1 chk("beq_ctl", 32'(bus.alu_ctl), 32'h6);
    next_edge();
    chk("beq_eq_out", bus.alu_out, 32'd0);
    chk("beq_eq_zero", 32'(bus.zero), 32'd1);
    drive(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1235, 32'h14);
    next_edge();
    chk("beq_ne_out", bus.alu_out, 32'hFFFF_FFFF);
    chk("beq_ne_zero", 32'(bus.zero), 32'd0);

    // SLT signed both directions
    drive(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h18);
    #1 chk("slt_ctl", 32'(bus.alu_ctl), 32'h7);
    next_edge();
    chk("slt_lt", bus.alu_out, 32'd1);
    drive(1'b1, 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h1C);
    next_edge();
    chk("slt_ge", bus.alu_out, 32'd0);
    chk("slt_ge_zero", 32'(bus.zero), 32'd1);

    // Logic ops
    drive(1'b1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h20);
    next_edge();
    chk("and_out", bus.alu_out, 32'h00F0_00F0);
    drive(1'b1, 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h24);
    next_edge();
    chk("or_out", bus.alu_out, 32'hFFF0_FFF0);
    drive(1'b1, 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h28);
    #1 chk("nor_ctl", 32'(bus.alu_ctl), 32'hC);
    next_edge();
    chk("nor_out", bus.alu_out, 32'h000F_000F);

    // Illegal funct
    drive(1'b1, 2'b10, 6'b000000, 32'h55, 32'h66, 32'h2C);
    #1 chk("ill_ctl", 32'(bus.alu_ctl), 32'hF);
    next_edge();
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_out", bus.alu_out, 32'd0);

    // PC wrap with addi
    drive(1'b1, 2'b11, 6'd0, 32'd5, 32'd7, 32'hFFFF_FFFC);
    next_edge();
    chk("pc_wrap", bus.pc_plus4, 32'd0);
    chk("addi_out", bus.alu_out, 32'd12);
    chk("addi_illegal", 32'(bus.illegal), 32'd0);

    // valid_in=0 holds data
    drive(1'b0, 2'b10, 6'b100010, 32'd100, 32'd1, 32'h40);
    next_edge();
    chk("hold_out", bus.alu_out, 32'd12);
    chk("hold_pc", bus.pc_plus4, 32'd0);
    chk("hold_valid", 32'(bus.valid_out), 32'd0);
    drive(1'b1, 2'b00, 6'd0, 32'd1, 32'd2, 32'h100);
    next_edge();
    chk("reload_pc", bus.pc_plus4, 32'h104);

    // Async reset mid-run, away from clock edges
    #1 reset = 1'b1;
    #1;
    chk("areset_out", bus.alu_out, 32'd0);
    chk("areset_zero", 32'(bus.zero), 32'd1);
    chk("areset_pc", bus.pc_plus4, 32'd0);
    chk("areset_valid", 32'(bus.valid_out), 32'd0);
    #1 reset = 1'b0;

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  f;
      next_edge();
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFF;
      f = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
      drive(($urandom_range(0, 3) != 0), 2'($urandom), f, a, b,
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2);
      if (i == 200) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    next_edge();
    next_edge();
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
